// File: rtl/mux_pipe_reg.sv
// N:1 selector feeding a registered valid/ready output stage with a one-entry skid
// buffer, flush, and out-of-range select flagging.
module mux_pipe_reg #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        select,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  if (SEL_W != $clog2(NUM_IN) || NUM_IN < 2 || NUM_IN > 256) begin : g_bad_cfg
    $error("mux_pipe_reg: NUM_IN must be 2..256 and SEL_W must equal clog2(NUM_IN)");
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } beat_t;

  beat_t m_q, m_d, s_q, s_d, cap;
  logic  m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic  xfer_in, m_drain;

  // Ready depends only on skid occupancy, so stalls never ripple combinationally upstream.
  assign in_ready  = !s_vld_q && !reset;
  assign xfer_in   = in_valid && in_ready;
  assign m_drain   = !m_vld_q || out_ready;

  assign out_data  = m_q.data;
  assign out_sel   = m_q.sel;
  assign out_err   = m_q.err;
  assign out_valid = m_vld_q;

  always_comb begin
    cap      = '0;
    cap.sel  = select;
    cap.err  = {{(32-SEL_W){1'b0}}, select} >= 32'(NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (select == SEL_W'(k)) cap.data = in_bus[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (m_drain) begin
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = xfer_in;
        if (xfer_in) s_d = cap;
      end else begin
        m_vld_d = xfer_in;
        if (xfer_in) m_d = cap;
      end
    end else if (xfer_in) begin
      s_d     = cap;
      s_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

endmodule
